capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
//  Sequences one capture frame through the sample RAM (simple dual-port, 1 write + 1 read port, same clk).
//  Writes ADC samples circularly, keeps pretrig_len samples before the trigger and fills the rest after it.
//  Then streams the whole frame, oldest sample first, to the display path over a valid/ready port.
//  Sits between the ADC front end, the sample RAM and the waveform renderer.
// PARAMETERS
//  DATA_WIDTH  10  sample width; must match the RAM DATA_WIDTH.
//  ADDR_WIDTH  14  RAM address width; frame length DEPTH = 2**ADDR_WIDTH.
//  RD_LATENCY  1   RAM read latency in clocks: 1 when RAM OUTPUT_REG="FALSE", 2 when "TRUE".
// PORTS
//  clk          in   1           single clock for the block and the RAM.
//  reset        in   1           synchronous, active-high.
//  arm          in   1           1-cycle pulse; starts a capture when in IDLE.
//  abort        in   1           return to IDLE from any state.
//  force_trig   in   1           trigger immediately while in WAIT_TRIG.
//  trig_slope   in   1           0 = rising edge, 1 = falling edge.
//  trig_level   in   DATA_WIDTH  trigger threshold, unsigned.
//  pretrig_len  in   ADDR_WIDTH  samples kept before the trigger; latched on arm.
//  adc_data     in   DATA_WIDTH  sample.
//  adc_valid    in   1           sample qualifier.
//  ram_wdata    out  DATA_WIDTH  RAM write data.
//  ram_waddr    out  ADDR_WIDTH  RAM write address.
//  ram_we       out  1           RAM write enable.
//  ram_raddr    out  ADDR_WIDTH  RAM read address.
//  ram_re       out  1           RAM read enable.
//  ram_rdata    in   DATA_WIDTH  RAM read data.
//  out_data     out  DATA_WIDTH  frame sample.
//  out_valid    out  1           out_data is valid.
//  out_ready    in   1           consumer accepts out_data.
//  out_last     out  1           marks the final (DEPTH-th) sample of the frame.
//  busy         out  1           1 in any state except IDLE.
//  state_o      out  3           IDLE=0, PREFILL=1, WAIT_TRIG=2, POST=3, READ=4.
// BEHAVIOUR
//  - Reset: state=IDLE; wptr=0; all counters=0; ram_we, ram_re, out_valid, out_last, busy = 0.
//    ram_waddr, ram_raddr, ram_wdata, out_data = 0. The sample history register prev is cleared.
//  - Writes happen in PREFILL, WAIT_TRIG and POST only:
//    ram_we = adc_valid, ram_waddr = wptr, ram_wdata = adc_data, all combinational.
//    wptr increments mod DEPTH on each write; wrap from DEPTH-1 to 0 is silent.
//  - IDLE: arm moves to PREFILL. On arm, plen = min(pretrig_len, DEPTH-1) is latched and cnt = 0.
//    arm received outside IDLE is ignored.
//  - PREFILL: cnt counts writes. When cnt reaches plen, move to WAIT_TRIG.
//    If plen = 0, move straight to WAIT_TRIG one cycle after arm.
//  - WAIT_TRIG: a trigger is a valid sample s, with prev = the previous valid sample, such that:
//    rising:  prev < trig_level && s >= trig_level
//    falling: prev > trig_level && s <= trig_level
//    prev updates on every valid sample in every capture state; it is not compared after reset/arm
//    until one sample has been seen. Triggers during PREFILL are ignored.
//    On trigger (or force_trig, which uses the current wptr), that sample is written as usual.
//    tptr = its address is captured, then move to POST with cnt = 1.
//  - POST: cnt counts writes including the trigger sample. When cnt = DEPTH - plen, move to READ.
//    rptr = tptr - plen (mod DEPTH) and rcnt = 0 are set at that point.
//  - READ: one read in flight at a time.
//    Pulse ram_re for 1 cycle with ram_raddr = rptr.
//    Capture ram_rdata exactly RD_LATENCY cycles later into out_data and set out_valid.
//    Hold out_data and out_valid stable until out_valid && out_ready.
//    Then rptr++ (mod DEPTH), rcnt++, and issue the next read in the following cycle.
//    out_last = out_valid && rcnt = DEPTH-1. After that beat is accepted, return to IDLE.
//  - abort or reset takes effect mid-operation on the next clock edge: go to IDLE, drop out_valid.
//    A read in flight is discarded. RAM contents are left as they are.
//  - abort has priority over arm, force_trig and trigger. reset has priority over all.
//  - All pointer arithmetic is unsigned, ADDR_WIDTH bits, modulo DEPTH.
// TESTING
//  Use ADDR_WIDTH=4 (DEPTH=16) with a behavioural RAM model.
//  - Ramp 0,1,2,... with adc_valid=1; plen=4, rising edge, level=20.
//    -> tptr=20 mod 16=4; output is 16 beats 16..31; out_last on 31.
//  - Same stimulus with plen=0. -> first beat is 20; out_last on 35.
//  - Constant 5 with level=20, then force_trig after 30 cycles. -> exactly 16 beats output, 4 of them before the force sample.
//  - out_ready toggling 1010... -> out_data stable while !out_ready; no sample lost or duplicated.
//    Repeat with RD_LATENCY=2.
//  - Assert abort in POST, then arm again. -> IDLE next cycle with busy=0; second capture completes with correct order.
//  - adc_valid low 2 of 3 cycles during capture, with a falling edge and pretrig_len=31 (clamped to 15).
//    -> only valid samples are written; first beat is 15 samples before the trigger.

Source files
------------

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences one capture frame through a simple dual-port sample RAM.
// ADC samples are written circularly. pretrig_len samples are kept ahead of the
// trigger, and the rest of the frame is filled after it. The whole frame is then
// streamed out oldest-first over a valid/ready port, with one RAM read in flight.
module capture_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trig,
    input  logic                  trig_slope,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_valid,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [2:0]            state_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Sample counters must reach DEPTH itself (plen = 0), so they carry one extra bit.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam int LW = $clog2(RD_LATENCY + 1);
    localparam logic [LW-1:0] LAT_C = LW'(RD_LATENCY);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        READ      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   plen_q, plen_d;
    logic [DATA_WIDTH-1:0]   prev_q, prev_d;
    logic                    prev_vld_q, prev_vld_d;
    logic [ADDR_WIDTH-1:0]   tptr_q, tptr_d;
    logic [ADDR_WIDTH-1:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH-1:0]   rcnt_q, rcnt_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [LW-1:0]           lat_q, lat_d;
    logic                    ram_re_q, ram_re_d;
    logic [ADDR_WIDTH-1:0]   ram_raddr_q, ram_raddr_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;

    logic                    capturing;
    logic                    wr_en;
    logic [CW-1:0]           cnt_inc;
    logic [CW-1:0]           post_len;
    logic                    rise_hit;
    logic                    fall_hit;
    logic                    edge_hit;
    logic                    enter_read;

    // Write side is purely combinational from the current state and ADC port.
    assign capturing = (state_q == PREFILL) || (state_q == WAIT_TRIG) || (state_q == POST);
    assign wr_en     = capturing && adc_valid;
    assign ram_we    = wr_en;
    assign ram_waddr = wptr_q;
    assign ram_wdata = capturing ? adc_data : '0;

    // Count including the write happening this cycle, so a phase ends on the exact
    // write that completes it rather than one write late.
    assign cnt_inc  = cnt_q + CW'(wr_en);
    assign post_len = DEPTH_C - {1'b0, plen_q};

    // Edge detection against the previous valid sample; needs one sample of history.
    assign rise_hit = prev_vld_q && (prev_q < trig_level) && (adc_data >= trig_level);
    assign fall_hit = prev_vld_q && (prev_q > trig_level) && (adc_data <= trig_level);
    assign edge_hit = adc_valid && (trig_slope ? fall_hit : rise_hit);

    // Next-state logic for the sequencer, pointers and output stage.
    always_comb begin
        // NOTE: every _d starts from its hold value so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        plen_d      = plen_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        tptr_d      = tptr_q;
        rptr_d      = rptr_q;
        rcnt_d      = rcnt_q;
        rd_pend_d   = rd_pend_q;
        lat_d       = lat_q;
        ram_re_d    = 1'b0;
        ram_raddr_d = ram_raddr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        enter_read  = 1'b0;

        if (wr_en) begin
            wptr_d     = wptr_q + ADDR_WIDTH'(1);
            prev_d     = adc_data;
            prev_vld_d = 1'b1;
        end

        // Read pipeline: a read issued last cycle lands RD_LATENCY edges after issue.
        if (ram_re_q) begin
            rd_pend_d = 1'b1;
            lat_d     = LW'(1);
        end else if (rd_pend_q) begin
            if (lat_q == LAT_C) begin
                out_data_d  = ram_rdata;
                out_valid_d = 1'b1;
                rd_pend_d   = 1'b0;
            end else begin
                lat_d = lat_q + LW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = PREFILL;
                    // The port is ADDR_WIDTH bits wide, so it is already bounded by DEPTH-1.
                    plen_d     = pretrig_len;
                    cnt_d      = '0;
                    prev_vld_d = 1'b0;
                end
            end
            PREFILL: begin
                cnt_d = cnt_inc;
                if ((plen_q == '0) || (cnt_inc == {1'b0, plen_q})) begin
                    state_d = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (force_trig || edge_hit) begin
                    tptr_d = wptr_q;
                    cnt_d  = CW'(wr_en);
                    if (CW'(wr_en) == post_len) begin
                        enter_read = 1'b1;
                    end else begin
                        state_d = POST;
                    end
                end
            end
            POST: begin
                cnt_d = cnt_inc;
                if (cnt_inc == post_len) begin
                    enter_read = 1'b1;
                end
            end
            READ: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    rptr_d      = rptr_q + ADDR_WIDTH'(1);
                    rcnt_d      = rcnt_q + ADDR_WIDTH'(1);
                    if (rcnt_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        ram_re_d    = 1'b1;
                        ram_raddr_d = rptr_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame complete: oldest sample sits plen slots before the trigger address.
        if (enter_read) begin
            state_d     = READ;
            rptr_d      = tptr_d - plen_q;
            rcnt_d      = '0;
            ram_re_d    = 1'b1;
            ram_raddr_d = rptr_d;
        end

        // Abort wins over everything else and discards any read still in flight.
        if (abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            ram_re_d    = 1'b0;
            rd_pend_d   = 1'b0;
        end
    end

    assign out_last_d = out_valid_d && (rcnt_d == LAST_IDX);
    assign busy_d     = (state_d != IDLE);

    // Register all state and outputs; synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop captures its pre-edge _d value regardless of order.
        if (reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            cnt_q       <= '0;
            plen_q      <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            tptr_q      <= '0;
            rptr_q      <= '0;
            rcnt_q      <= '0;
            rd_pend_q   <= 1'b0;
            lat_q       <= '0;
            ram_re_q    <= 1'b0;
            ram_raddr_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            plen_q      <= plen_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            tptr_q      <= tptr_d;
            rptr_q      <= rptr_d;
            rcnt_q      <= rcnt_d;
            rd_pend_q   <= rd_pend_d;
            lat_q       <= lat_d;
            ram_re_q    <= ram_re_d;
            ram_raddr_q <= ram_raddr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_re    = ram_re_q;
    assign ram_raddr = ram_raddr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed bench for capture_ctrl with DEPTH=16.
// Two instances share all stimulus: one with RD_LATENCY=1, one with RD_LATENCY=2,
// each with its own behavioural RAM. Expected beats are hand-computed per test.
module tb_capture_ctrl;

    localparam int DW    = 10;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int BUDGET = 1000;

    typedef enum int {M_RAMP, M_FORCE, M_SPARSE} mode_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic          abort;
    logic          force_trig;
    logic          trig_slope;
    logic [DW-1:0] trig_level;
    logic [AW-1:0] pretrig_len;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          out_ready;

    logic [DW-1:0] ram_wdata1, ram_rdata1, out_data1;
    logic [AW-1:0] ram_waddr1, ram_raddr1;
    logic          ram_we1, ram_re1, out_valid1, out_last1, busy1;
    logic [2:0]    state1;

    logic [DW-1:0] ram_wdata2, ram_rdata2, out_data2;
    logic [AW-1:0] ram_waddr2, ram_raddr2;
    logic          ram_we2, ram_re2, out_valid2, out_last2, busy2;
    logic [2:0]    state2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .force_trig(force_trig),
        .trig_slope(trig_slope), .trig_level(trig_level), .pretrig_len(pretrig_len),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .ram_wdata(ram_wdata1), .ram_waddr(ram_waddr1), .ram_we(ram_we1),
        .ram_raddr(ram_raddr1), .ram_re(ram_re1), .ram_rdata(ram_rdata1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_last(out_last1), .busy(busy1), .state_o(state1)
    );

    capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .force_trig(force_trig),
        .trig_slope(trig_slope), .trig_level(trig_level), .pretrig_len(pretrig_len),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .ram_wdata(ram_wdata2), .ram_waddr(ram_waddr2), .ram_we(ram_we2),
        .ram_raddr(ram_raddr2), .ram_re(ram_re2), .ram_rdata(ram_rdata2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_last(out_last2), .busy(busy2), .state_o(state2)
    );

    // Behavioural RAMs: latency 1 (unregistered output) and latency 2 (output register).
    // NOTE: the sample RAM is never reset; a frame only reads back slots it wrote itself.
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];
    logic [DW-1:0] rd1, rd2a, rd2b;

    always @(posedge clk) begin
        if (ram_we1) mem1[ram_waddr1] <= ram_wdata1;
        if (ram_re1) rd1 <= mem1[ram_raddr1];
        if (ram_we2) mem2[ram_waddr2] <= ram_wdata2;
        if (ram_re2) rd2a <= mem2[ram_raddr2];
        rd2b <= rd2a;
    end

    assign ram_rdata1 = rd1;
    assign ram_rdata2 = rd2b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Beat monitors: record accepted beats and check that a stalled beat stays put.
    logic [DW-1:0] q1[$], q2[$];
    bit            l1[$], l2[$];
    bit            hold1 = 1'b0, hold2 = 1'b0;
    logic [DW-1:0] held1, held2;

    always @(negedge clk) begin
        if (hold1) begin
            check("stall1_valid", 32'(out_valid1), 32'd1);
            check("stall1_data", 32'(out_data1), 32'(held1));
        end
        if (out_valid1 && out_ready) begin
            q1.push_back(out_data1);
            l1.push_back(out_last1);
        end
        hold1 = !reset && !abort && out_valid1 && !out_ready;
        held1 = out_data1;
    end

    always @(negedge clk) begin
        if (hold2) begin
            check("stall2_valid", 32'(out_valid2), 32'd1);
            check("stall2_data", 32'(out_data2), 32'(held2));
        end
        if (out_valid2 && out_ready) begin
            q2.push_back(out_data2);
            l2.push_back(out_last2);
        end
        hold2 = !reset && !abort && out_valid2 && !out_ready;
        held2 = out_data2;
    end

    function automatic int expect_val(input mode_t mode, input int first, input int i);
        case (mode)
            M_RAMP:   return first + i;
            M_SPARSE: return first - i;
            default:  return (i < 4) ? 5 : i + 2;
        endcase
    endfunction

    task automatic check_frame(input string tag, input logic [DW-1:0] q[$], input bit l[$],
                               input mode_t mode, input int exp_first, input int exp_beats);
        check({tag, "_beats"}, 32'(q.size()), 32'(exp_beats));
        for (int i = 0; i < q.size() && i < exp_beats; i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(q[i]), 32'(expect_val(mode, exp_first, i)));
            check($sformatf("%s_last%0d", tag, i), 32'(l[i]), 32'(i == exp_beats - 1));
        end
    endtask

    task automatic drive(input mode_t mode, input int c, input int base, input int force_at);
        case (mode)
            M_RAMP: begin
                adc_valid  = 1'b1;
                adc_data   = DW'(base + c);
                force_trig = 1'b0;
            end
            M_FORCE: begin
                adc_valid  = 1'b1;
                adc_data   = (c < force_at) ? DW'(5) : DW'(6 + c - force_at);
                force_trig = (c == force_at);
            end
            default: begin
                adc_valid  = (c % 3 == 0);
                adc_data   = adc_valid ? DW'(100 - c / 3) : '0;
                force_trig = 1'b0;
            end
        endcase
    endtask

    task automatic run_frame(input string tag, input mode_t mode, input int plen, input bit slope,
                             input int level, input int base, input int force_at, input int arm_at,
                             input int abort_at, input bit toggle_ready, input int exp_first,
                             input int exp_beats);
        int c;
        q1.delete(); q2.delete(); l1.delete(); l2.delete();
        @(posedge clk); #1;
        pretrig_len = AW'(plen);
        trig_slope  = slope;
        trig_level  = DW'(level);
        arm         = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        c   = 0;
        while ((busy1 || busy2) && c < BUDGET) begin
            drive(mode, c, base, force_at);
            arm       = (c == arm_at);
            abort     = (c == abort_at);
            out_ready = toggle_ready ? (c % 2 == 0) : 1'b1;
            @(negedge clk);
            if (arm_at >= 0 && c == arm_at + 1)
                check({tag, "_arm_ignored"}, 32'(state1), 32'd2);
            if (mode == M_RAMP && plen == 0 && c < 2)
                check($sformatf("%s_state_c%0d", tag, c), 32'(state1), 32'(c + 1));
            if (mode == M_FORCE && c == force_at)
                check({tag, "_pre_force_state"}, 32'(state1), 32'd2);
            if (mode == M_FORCE && c == force_at + 1)
                check({tag, "_post_force_state"}, 32'(state1), 32'd3);
            if (mode == M_SPARSE && c == 6) begin
                check({tag, "_we_valid"}, 32'(ram_we1), 32'd1);
                check({tag, "_wdata"}, 32'(ram_wdata1), 32'd98);
            end
            if (mode == M_SPARSE && c == 7)
                check({tag, "_we_invalid"}, 32'(ram_we1), 32'd0);
            @(posedge clk); #1;
            c++;
        end
        arm = 1'b0; abort = 1'b0; force_trig = 1'b0; adc_valid = 1'b0; out_ready = 1'b1;
        check({tag, "_done_in_budget"}, 32'(c < BUDGET), 32'd1);
        if (abort_at >= 0) begin
            check({tag, "_abort_cycle"}, 32'(c), 32'(abort_at + 1));
            check({tag, "_abort_state"}, 32'(state1), 32'd0);
            check({tag, "_abort_busy1"}, 32'(busy1), 32'd0);
            check({tag, "_abort_busy2"}, 32'(busy2), 32'd0);
            check({tag, "_abort_valid"}, 32'(out_valid1), 32'd0);
        end
        check_frame({tag, "_lat1"}, q1, l1, mode, exp_first, exp_beats);
        check_frame({tag, "_lat2"}, q2, l2, mode, exp_first, exp_beats);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; abort = 1'b0; force_trig = 1'b0; trig_slope = 1'b0;
        trig_level = '0; pretrig_len = '0; adc_data = '1; adc_valid = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_we", 32'(ram_we1), 32'd0);
        check("rst_re", 32'(ram_re1), 32'd0);
        check("rst_valid", 32'(out_valid1), 32'd0);
        check("rst_last", 32'(out_last1), 32'd0);
        check("rst_waddr", 32'(ram_waddr1), 32'd0);
        check("rst_raddr", 32'(ram_raddr1), 32'd0);
        check("rst_wdata", 32'(ram_wdata1), 32'd0);
        check("rst_odata", 32'(out_data1), 32'd0);
        check("rst_state2", 32'(state2), 32'd0);
        check("rst_valid2", 32'(out_valid2), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; adc_valid = 1'b0;

        // Ramp, plen=4, rising at 20, stray arm while waiting: beats 16..31.
        run_frame("ramp_p4", M_RAMP, 4, 1'b0, 20, 0, -1, 10, -1, 1'b0, 16, 16);
        // Ramp, plen=0: beats 20..35.
        run_frame("ramp_p0", M_RAMP, 0, 1'b0, 20, 0, -1, -1, -1, 1'b0, 20, 16);
        // Constant 5, forced at cycle 30: four 5s then 6..17.
        run_frame("force", M_FORCE, 4, 1'b0, 20, 0, 30, -1, -1, 1'b0, 0, 16);
        // Consumer stalls every other cycle: beats 218..233.
        run_frame("toggle", M_RAMP, 2, 1'b0, 220, 200, -1, -1, -1, 1'b1, 218, 16);
        // Abort in POST, then a fresh capture: beats 116..131.
        run_frame("abort", M_RAMP, 4, 1'b0, 20, 0, -1, -1, 24, 1'b0, 0, 0);
        run_frame("rearm", M_RAMP, 4, 1'b0, 120, 100, -1, -1, -1, 1'b0, 116, 16);
        // Sparse valid, falling at 50, pretrig 15: beats 65 down to 50.
        run_frame("sparse", M_SPARSE, 31, 1'b1, 50, 0, -1, -1, -1, 1'b0, 65, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
